busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Holds the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to decode on the 32-bit `saida` bus under a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding any in-flight read.

Parameters:
- PC_INICIAL, 32'h00000000, fetch PC after reset.
- PROFUNDIDADE, 2, FIFO entries; power of two, 2..8.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- mem_req  out  1  read request, held until acknowledged
- mem_addr  out  32  word address of request, bits [1:0] always 0
- mem_ack  in  1  read complete this cycle; ignored while mem_req=0
- mem_rdata  in  32  instruction word, valid when mem_ack=1
- desvio  in  1  redirect (taken branch/jump) this cycle
- alvo  in  32  redirect target; bits [1:0] forced to 0
- saida  out  32  instruction at FIFO head; 32'h00000013 (NOP) when empty
- pc_saida  out  32  PC of head instruction; 0 when empty
- valida  out  1  saida/pc_saida valid
- pronto  in  1  decode accepts head this cycle

Behaviour:
- Reset values: mem_req=0, mem_addr=PC_INICIAL, FIFO empty, valida=0, saida=32'h00000013, pc_saida=0, fetch PC=PC_INICIAL, state BUSCA_OCIOSA.
- Reset has priority over everything; a reset mid-transaction drops mem_req at that edge, and a late mem_ack is ignored.
- At most one outstanding read. Occupancy = FIFO count + in-flight read (0/1); never exceeds PROFUNDIDADE.
- State BUSCA_OCIOSA: if occupancy < PROFUNDIDADE and no desvio, assert mem_req with mem_addr = fetch PC → BUSCA_ESPERA.
- State BUSCA_ESPERA: mem_req/mem_addr held stable.
  - On mem_ack with no desvio: push {mem_addr, mem_rdata}; fetch PC += 4, wrapping modulo 2^32.
  - If the slot stays free (pop same cycle, or room remains), issue the next request back-to-back in the following cycle with the new address; otherwise → BUSCA_OCIOSA.
- State BUSCA_DESCARTE: mem_req/mem_addr held; on mem_ack the data is dropped; then issue a request to the stored target → BUSCA_ESPERA.
- desvio (any state):
  - FIFO flushed at that edge; valida=0 next cycle.
  - fetch PC ← {alvo[31:2],2'b00}.
  - If a read is in flight and mem_ack=0 this cycle → BUSCA_DESCARTE.
  - If mem_ack=1 this cycle, the word is dropped → BUSCA_OCIOSA.
  - desvio overrides simultaneous pop and push.
- Pop: when valida && pronto && !desvio, head advances.
- Push and pop in the same cycle are both allowed.
- Output latency:
  - saida/pc_saida are driven combinationally from the FIFO head register.
  - An instruction acked at edge N is visible (valida=1) from cycle N+1.
  - Minimum fetch-to-valid latency is 2 cycles (req, ack).
- Throughput: one instruction per cycle when mem_ack returns in the cycle following each request and pronto=1.
- Stall: with pronto=0, the FIFO fills to PROFUNDIDADE and mem_req stays 0; head outputs are held stable.
- Write and read pointers are log2(PROFUNDIDADE) bits and wrap naturally; full and empty are distinguished by a count register.

Test Plan:
- Reset, zero-wait memory returning addr+32'h100, pronto=1 → mem_addr 0,4,8,…; pc_saida 0,4,8 with saida 32'h100,32'h104,32'h108 on consecutive cycles from cycle 2.
- pronto=0, PROFUNDIDADE=2 → exactly 2 requests (0,4); mem_req low afterward; saida/pc_saida held at instruction@0/0. Raising pronto resumes fetch at 8.
- desvio with alvo=32'h0000_0203 while a read to 8 is outstanding with ack delayed 3 cycles → FIFO flushed, ack data for 8 discarded, next mem_addr=32'h200, first valid pc_saida=32'h200.
- desvio in the same cycle as mem_ack and pronto → no push, no pop, valida=0 next cycle, next mem_addr=alvo.
- PC_INICIAL=32'hFFFF_FFFC → fetch addresses FFFF_FFFC then 0000_0000 (wrap).
- Reset asserted during BUSCA_ESPERA, with mem_ack arriving 1 cycle later → mem_req=0, ack ignored, valida=0; fetch restarts at PC_INICIAL.

Source files
------------

// File: rtl/busca_instrucao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | busca_instrucao: instruction fetch with req/ack memory port and FIFO     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module busca_instrucao #(
  parameter logic [31:0] PC_INICIAL   = 32'h0000_0000,
  parameter int          PROFUNDIDADE = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        desvio,
  input  logic [31:0] alvo,
  output logic [31:0] saida,
  output logic [31:0] pc_saida,
  output logic        valida,
  input  logic        pronto
);

  localparam int          PW        = $clog2(PROFUNDIDADE);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] c_pc_ini  = PC_INICIAL & 32'hFFFF_FFFC;
  localparam logic [31:0] c_nop     = 32'h0000_0013;
  localparam logic [CW-1:0] c_prof  = CW'(PROFUNDIDADE);
  localparam logic [CW-1:0] c_um    = CW'(1);

  typedef enum logic [1:0] {
    BUSCA_OCIOSA   = 2'd0,
    BUSCA_ESPERA   = 2'd1,
    BUSCA_DESCARTE = 2'd2
  } estado_t;

  estado_t r_estado, w_estado_next;

  logic          r_mem_req, w_req_next;
  logic [31:0]   r_mem_addr, w_addr_next;
  logic [31:0]   r_pc, w_pc_next;
  logic [31:0]   w_pc_mais4;
  logic [31:0]   w_alvo;

  logic [31:0]   r_fifo_instr [PROFUNDIDADE];
  logic [31:0]   r_fifo_pc    [PROFUNDIDADE];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count, w_count_next, w_count_com_push;

  logic          w_ack, w_push, w_pop, w_valida;

  // An ack is only meaningful while a request is actually outstanding.
  assign w_ack            = mem_ack & r_mem_req;
  assign w_valida         = (r_count != '0);
  assign w_pop            = w_valida & pronto & ~desvio;
  assign w_pc_mais4       = r_pc + 32'd4;
  assign w_alvo           = alvo & 32'hFFFF_FFFC;
  assign w_count_com_push = w_pop ? r_count : (r_count + c_um);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= BUSCA_OCIOSA;
      r_mem_req  <= 1'b0;
      r_mem_addr <= c_pc_ini;
      r_pc       <= c_pc_ini;
    end else begin
      r_estado   <= w_estado_next;
      r_mem_req  <= w_req_next;
      r_mem_addr <= w_addr_next;
      r_pc       <= w_pc_next;
    end
  end

  always_comb begin
    w_estado_next = r_estado;
    w_req_next    = r_mem_req;
    w_addr_next   = r_mem_addr;
    w_pc_next     = r_pc;
    w_push        = 1'b0;
    if (desvio) begin
      w_pc_next = w_alvo;
      // A read still in flight must be drained before the target is fetched.
      if (r_estado != BUSCA_OCIOSA && !w_ack) begin
        w_estado_next = BUSCA_DESCARTE;
      end else begin
        w_estado_next = BUSCA_OCIOSA;
        w_req_next    = 1'b0;
      end
    end else begin
      case (r_estado)
        BUSCA_OCIOSA: begin
          if (r_count < c_prof) begin
            w_req_next    = 1'b1;
            w_addr_next   = r_pc;
            w_estado_next = BUSCA_ESPERA;
          end
        end
        BUSCA_ESPERA: begin
          if (w_ack) begin
            w_push    = 1'b1;
            w_pc_next = w_pc_mais4;
            if (w_count_com_push < c_prof) begin
              w_addr_next = w_pc_mais4;
            end else begin
              w_req_next    = 1'b0;
              w_estado_next = BUSCA_OCIOSA;
            end
          end
        end
        BUSCA_DESCARTE: begin
          if (w_ack) begin
            w_req_next    = 1'b1;
            w_addr_next   = r_pc;
            w_estado_next = BUSCA_ESPERA;
          end
        end
        default: begin
          w_req_next    = 1'b0;
          w_estado_next = BUSCA_OCIOSA;
        end
      endcase
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_um;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_um;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || desvio) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_instr[r_wr] <= mem_rdata;
      r_fifo_pc[r_wr]    <= r_mem_addr;
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign valida   = w_valida;
  assign saida    = w_valida ? r_fifo_instr[r_rd] : c_nop;
  assign pc_saida = w_valida ? r_fifo_pc[r_rd]    : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_busca_instrucao: directed bench for busca_instrucao                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        desvio;
  logic [31:0] alvo;
  logic [31:0] saida, pc_saida;
  logic        valida, pronto;
  logic        ack_en, ack_force;

  logic        req_w, ack_w, valida_w;
  logic [31:0] addr_w, rdata_w, saida_w, pc_saida_w;

  int n_total = 0;
  int n_ok    = 0;

  // Memory returns addr+0x100; ack gated by the bench to model latency.
  assign mem_ack   = (mem_req & ack_en) | ack_force;
  assign mem_rdata = mem_addr + 32'h100;
  assign ack_w     = req_w;
  assign rdata_w   = addr_w + 32'h100;

  busca_instrucao dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .desvio(desvio), .alvo(alvo),
    .saida(saida), .pc_saida(pc_saida), .valida(valida), .pronto(pronto)
  );

  busca_instrucao #(.PC_INICIAL(32'hFFFF_FFFC), .PROFUNDIDADE(2)) dut_w (
    .clock(clock), .reset(reset),
    .mem_req(req_w), .mem_addr(addr_w), .mem_ack(ack_w), .mem_rdata(rdata_w),
    .desvio(1'b0), .alvo(32'h0),
    .saida(saida_w), .pc_saida(pc_saida_w), .valida(valida_w), .pronto(1'b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_total++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: obtido=%h esperado=%h", tag, obs, esp);
  endtask

  task automatic ciclo();
    @(negedge clock);
  endtask

  task automatic espera_req(input string tag, input int max);
    int k = 0;
    while (!mem_req && k < max) begin
      ciclo();
      k++;
    end
    verifica(tag, {31'b0, mem_req}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; pronto = 1'b1; desvio = 1'b0; alvo = 32'h0;
    ack_en = 1'b1; ack_force = 1'b0;
    ciclo(); ciclo();
    verifica("rst_req",   {31'b0, mem_req}, 32'd0);
    verifica("rst_addr",  mem_addr, 32'h0);
    verifica("rst_val",   {31'b0, valida}, 32'd0);
    verifica("rst_saida", saida, 32'h13);
    verifica("rst_pc",    pc_saida, 32'h0);
    verifica("rst_addr_w", addr_w, 32'hFFFF_FFFC);

    // Streaming with zero-wait memory
    reset = 1'b0;
    ciclo();
    verifica("s1_req",  {31'b0, mem_req}, 32'd1);
    verifica("s1_addr", mem_addr, 32'h0);
    verifica("s1_val",  {31'b0, valida}, 32'd0);
    verifica("w_addr0", addr_w, 32'hFFFF_FFFC);
    ciclo();
    verifica("w_addr1", addr_w, 32'h0);
    verifica("w_pc0",   pc_saida_w, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      verifica("str_val",   {31'b0, valida}, 32'd1);
      verifica("str_pc",    pc_saida, 32'(4 * i));
      verifica("str_saida", saida, 32'(32'h100 + 4 * i));
      verifica("str_addr",  mem_addr, 32'(4 * (i + 1)));
      if (i == 0) begin
        ciclo();
        verifica("w_pc1",    pc_saida_w, 32'h0);
        verifica("w_saida1", saida_w, 32'h100);
      end else begin
        ciclo();
      end
    end

    // Stall: pronto=0 fills the FIFO after two requests
    reset = 1'b1; pronto = 1'b0;
    ciclo();
    reset = 1'b0;
    ciclo();
    verifica("st_addr0", mem_addr, 32'h0);
    ciclo();
    verifica("st_addr1", mem_addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      ciclo();
      verifica("st_req",   {31'b0, mem_req}, 32'd0);
      verifica("st_pc",    pc_saida, 32'h0);
      verifica("st_saida", saida, 32'h100);
    end
    pronto = 1'b1; ack_en = 1'b0;
    ciclo();
    verifica("st_pc4", pc_saida, 32'h4);
    verifica("st_s4",  saida, 32'h104);
    espera_req("res_req", 5);
    verifica("res_addr", mem_addr, 32'h8);
    verifica("res_val",  {31'b0, valida}, 32'd0);

    // Redirect while the read to 8 is outstanding
    desvio = 1'b1; alvo = 32'h0000_0203;
    ciclo();
    desvio = 1'b0;
    verifica("dc_req",  {31'b0, mem_req}, 32'd1);
    verifica("dc_addr", mem_addr, 32'h8);
    verifica("dc_val",  {31'b0, valida}, 32'd0);
    ciclo();
    ack_en = 1'b1;
    ciclo();
    verifica("dc_val2",  {31'b0, valida}, 32'd0);
    verifica("dc_addr2", mem_addr, 32'h200);
    ciclo();
    verifica("dc_pc",    pc_saida, 32'h200);
    verifica("dc_saida", saida, 32'h300);

    // Redirect coincident with ack and pop
    verifica("dp_ack", {31'b0, mem_ack}, 32'd1);
    desvio = 1'b1; alvo = 32'h0000_0400;
    ciclo();
    desvio = 1'b0;
    verifica("dp_val",   {31'b0, valida}, 32'd0);
    verifica("dp_saida", saida, 32'h13);
    verifica("dp_pc",    pc_saida, 32'h0);
    espera_req("dp_req", 5);
    verifica("dp_addr", mem_addr, 32'h400);
    ciclo();
    verifica("dp_pc2", pc_saida, 32'h400);
    verifica("dp_s2",  saida, 32'h500);

    // Reset in the middle of a pending read, late ack afterwards
    ack_en = 1'b0;
    ciclo();
    verifica("rm_pend", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    ciclo();
    reset = 1'b0; ack_force = 1'b1;
    verifica("rm_req", {31'b0, mem_req}, 32'd0);
    verifica("rm_val", {31'b0, valida}, 32'd0);
    ciclo();
    ack_force = 1'b0;
    verifica("rm_req2", {31'b0, mem_req}, 32'd1);
    verifica("rm_addr", mem_addr, 32'h0);
    verifica("rm_val2", {31'b0, valida}, 32'd0);
    ack_en = 1'b1;
    ciclo();
    verifica("rm_pc",    pc_saida, 32'h0);
    verifica("rm_saida", saida, 32'h100);

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
`default_nettype wire
